// File: rtl/backprop_scheduler.sv
// rtl/backprop_scheduler.sv - sequences per-layer backprop passes over samples and epochs
module backprop_scheduler #(
    parameter int NEURON_NUM          = 4,
    parameter int NEURON_OUTPUT_WIDTH = 10,
    parameter int LAYER_ADDR_WIDTH    = 1,
    parameter int LAYER_MAX           = 0,
    parameter int SAMPLE_ADDR_SIZE    = 10,
    parameter int SAMPLE_NUM          = 1000,
    parameter int EPOCH_WIDTH         = 16
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [EPOCH_WIDTH-1:0]                    num_epochs,
    input  logic                                      stop,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      halted,
    output logic                                      err_flag,
    output logic [EPOCH_WIDTH-1:0]                    cur_epoch,
    output logic [SAMPLE_ADDR_SIZE-1:0]               cur_sample,
    output logic [LAYER_ADDR_WIDTH-1:0]               cur_layer,
    output logic                                      act_rd_en,
    output logic [LAYER_ADDR_WIDTH-1:0]               act_rd_layer,
    output logic [SAMPLE_ADDR_SIZE-1:0]               act_rd_sample,
    input  logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0] act_z,
    input  logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0] act_z_prev,
    output logic [LAYER_ADDR_WIDTH-1:0]               bp_layer,
    output logic                                      bp_layer_valid,
    input  logic                                      bp_layer_ready,
    output logic [SAMPLE_ADDR_SIZE-1:0]               bp_sample,
    output logic                                      bp_sample_valid,
    input  logic                                      bp_sample_ready,
    output logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0] bp_z,
    output logic                                      bp_z_valid,
    input  logic                                      bp_z_ready,
    output logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0] bp_z_prev,
    output logic                                      bp_z_prev_valid,
    input  logic                                      bp_z_prev_ready,
    input  logic                                      bp_weights_valid,
    output logic                                      bp_weights_ready,
    input  logic                                      bp_error
);
    localparam int ZW = NEURON_NUM * NEURON_OUTPUT_WIDTH;
    localparam logic [LAYER_ADDR_WIDTH-1:0] LAYER_TOP   = LAYER_ADDR_WIDTH'(LAYER_MAX);
    localparam logic [SAMPLE_ADDR_SIZE-1:0] LAST_SAMPLE = SAMPLE_ADDR_SIZE'(SAMPLE_NUM - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_ISSUE, S_WAIT_W, S_NEXT, S_DONE
    } state_t;

    state_t                      state_q;
    logic [EPOCH_WIDTH-1:0]      epoch_last_q, epoch_q;
    logic [SAMPLE_ADDR_SIZE-1:0] sample_q, bp_sample_q;
    logic [LAYER_ADDR_WIDTH-1:0] layer_q, bp_layer_q;
    logic [ZW-1:0]               bp_z_q, bp_z_prev_q;
    logic                        stop_q, err_q, halted_q, done_q, rd_en_q, wready_q;
    // valid bit order: {z_prev, z, sample, layer}
    logic [3:0]                  valid_q, valid_d, ready_in;

    assign ready_in = {bp_z_prev_ready, bp_z_ready, bp_sample_ready, bp_layer_ready};
    assign valid_d  = valid_q & ~ready_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            epoch_last_q <= '0;
            epoch_q      <= '0;
            sample_q     <= '0;
            layer_q      <= '0;
            bp_layer_q   <= '0;
            bp_sample_q  <= '0;
            bp_z_q       <= '0;
            bp_z_prev_q  <= '0;
            valid_q      <= '0;
            stop_q       <= 1'b0;
            err_q        <= 1'b0;
            halted_q     <= 1'b0;
            done_q       <= 1'b0;
            rd_en_q      <= 1'b0;
            wready_q     <= 1'b0;
        end else begin
            err_q   <= err_q | bp_error;
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            if (state_q != S_IDLE) stop_q <= stop_q | stop;
            case (state_q)
                S_IDLE: if (start) begin
                    epoch_last_q <= (num_epochs == '0) ? '0 : num_epochs - EPOCH_WIDTH'(1);
                    epoch_q      <= '0;
                    sample_q     <= '0;
                    layer_q      <= LAYER_TOP;
                    err_q        <= bp_error;
                    halted_q     <= 1'b0;
                    stop_q       <= 1'b0;
                    rd_en_q      <= 1'b1;
                    state_q      <= S_FETCH;
                end
                S_FETCH: state_q <= S_LATCH;
                S_LATCH: begin
                    bp_z_q      <= act_z;
                    bp_z_prev_q <= act_z_prev;
                    bp_layer_q  <= layer_q;
                    bp_sample_q <= sample_q;
                    valid_q     <= 4'hf;
                    state_q     <= S_ISSUE;
                end
                S_ISSUE: begin
                    valid_q <= valid_d;
                    if (valid_d == '0) begin
                        wready_q <= 1'b1;
                        state_q  <= S_WAIT_W;
                    end
                end
                S_WAIT_W: if (bp_weights_valid) begin
                    wready_q <= 1'b0;
                    state_q  <= S_NEXT;
                end
                S_NEXT: begin
                    if (stop_q || err_q) begin
                        halted_q <= 1'b1;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else if (layer_q != '0) begin
                        layer_q <= layer_q - LAYER_ADDR_WIDTH'(1);
                        rd_en_q <= 1'b1;
                        state_q <= S_FETCH;
                    end else if (sample_q != LAST_SAMPLE) begin
                        sample_q <= sample_q + SAMPLE_ADDR_SIZE'(1);
                        layer_q  <= LAYER_TOP;
                        rd_en_q  <= 1'b1;
                        state_q  <= S_FETCH;
                    end else if (epoch_q != epoch_last_q) begin
                        epoch_q  <= epoch_q + EPOCH_WIDTH'(1);
                        sample_q <= '0;
                        layer_q  <= LAYER_TOP;
                        rd_en_q  <= 1'b1;
                        state_q  <= S_FETCH;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy             = (state_q != S_IDLE);
    assign done             = done_q;
    assign halted           = halted_q;
    assign err_flag         = err_q;
    assign cur_epoch        = epoch_q;
    assign cur_sample       = sample_q;
    assign cur_layer        = layer_q;
    assign act_rd_en        = rd_en_q;
    assign act_rd_layer     = layer_q;
    assign act_rd_sample    = sample_q;
    assign bp_layer         = bp_layer_q;
    assign bp_sample        = bp_sample_q;
    assign bp_z             = bp_z_q;
    assign bp_z_prev        = bp_z_prev_q;
    assign bp_layer_valid   = valid_q[0];
    assign bp_sample_valid  = valid_q[1];
    assign bp_z_valid       = valid_q[2];
    assign bp_z_prev_valid  = valid_q[3];
    assign bp_weights_ready = wready_q;
endmodule

// File: tb/tb_backprop_scheduler.sv
// tb/tb_backprop_scheduler.sv - directed scoreboard bench for backprop_scheduler
module tb_backprop_scheduler;
    localparam int NN = 4, NW = 10, LW = 1, LMAX = 1, SW = 2, SNUM = 2, EW = 16;
    localparam int ZW = NN * NW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0, stop = 1'b0, bp_error = 1'b0;
    logic [EW-1:0] num_epochs = '0;
    logic          busy, done, halted, err_flag, act_rd_en;
    logic [EW-1:0] cur_epoch;
    logic [SW-1:0] cur_sample, act_rd_sample, bp_sample;
    logic [LW-1:0] cur_layer, act_rd_layer, bp_layer;
    logic [ZW-1:0] act_z = '0, act_z_prev = '0, bp_z, bp_z_prev;
    logic          bp_layer_valid, bp_sample_valid, bp_z_valid, bp_z_prev_valid;
    logic          bp_layer_ready = 1'b1, bp_sample_ready = 1'b1;
    logic          bp_z_ready = 1'b1, bp_z_prev_ready = 1'b1;
    logic          bp_weights_valid = 1'b1, bp_weights_ready;

    typedef struct packed {
        logic [EW-1:0] e;
        logic [SW-1:0] s;
        logic [LW-1:0] l;
    } pass_t;
    pass_t sb[$];

    int checks = 0, errors = 0;
    int rd_pulses = 0, long_rd = 0, done_cnt = 0;
    logic prev_rd = 1'b0;

    backprop_scheduler #(
        .NEURON_NUM(NN), .NEURON_OUTPUT_WIDTH(NW), .LAYER_ADDR_WIDTH(LW), .LAYER_MAX(LMAX),
        .SAMPLE_ADDR_SIZE(SW), .SAMPLE_NUM(SNUM), .EPOCH_WIDTH(EW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_epochs(num_epochs), .stop(stop),
        .busy(busy), .done(done), .halted(halted), .err_flag(err_flag),
        .cur_epoch(cur_epoch), .cur_sample(cur_sample), .cur_layer(cur_layer),
        .act_rd_en(act_rd_en), .act_rd_layer(act_rd_layer), .act_rd_sample(act_rd_sample),
        .act_z(act_z), .act_z_prev(act_z_prev),
        .bp_layer(bp_layer), .bp_layer_valid(bp_layer_valid), .bp_layer_ready(bp_layer_ready),
        .bp_sample(bp_sample), .bp_sample_valid(bp_sample_valid), .bp_sample_ready(bp_sample_ready),
        .bp_z(bp_z), .bp_z_valid(bp_z_valid), .bp_z_ready(bp_z_ready),
        .bp_z_prev(bp_z_prev), .bp_z_prev_valid(bp_z_prev_valid), .bp_z_prev_ready(bp_z_prev_ready),
        .bp_weights_valid(bp_weights_valid), .bp_weights_ready(bp_weights_ready),
        .bp_error(bp_error)
    );

    always #5 clk = ~clk;

    function automatic logic [ZW-1:0] zfun(input int l, input int s);
        return {10'(300 + l), 10'(400 + s), 10'd600, 10'd700};
    endfunction

    function automatic logic [ZW-1:0] zpfun(input int l, input int s);
        return {10'(l), 10'(s), 10'd5, 10'd9};
    endfunction

    // Activation store: data is only meaningful the cycle after the strobe
    always @(posedge clk) begin
        if (act_rd_en) begin
            act_z      <= zfun(int'(act_rd_layer), int'(act_rd_sample));
            act_z_prev <= zpfun(int'(act_rd_layer), int'(act_rd_sample));
        end else begin
            act_z      <= '1;
            act_z_prev <= '1;
        end
    end

    always @(negedge clk) begin
        if (act_rd_en) rd_pulses++;
        if (act_rd_en && prev_rd) long_rd++;
        prev_rd = act_rd_en;
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_for(input int k, input string tag);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(negedge clk);
            case (k)
                0:       hit = bp_layer_valid;
                1:       hit = done;
                default: hit = bp_weights_ready;
            endcase
        end
        chk(tag, 64'(hit), 64'd1);
    endtask

    task automatic push(input int e, input int s, input int l);
        pass_t p;
        p.e = EW'(e);
        p.s = SW'(s);
        p.l = LW'(l);
        sb.push_back(p);
    endtask

    task automatic check_pass();
        pass_t p;
        wait_for(0, "issue_wait");
        if (sb.size() == 0) begin
            chk("sb_underflow", 64'(bp_layer_valid), 64'd0);
        end else begin
            p = sb.pop_front();
            chk("bp_layer", 64'(bp_layer), 64'(p.l));
            chk("bp_sample", 64'(bp_sample), 64'(p.s));
            chk("cur_epoch", 64'(cur_epoch), 64'(p.e));
            chk("bp_z", 64'(bp_z), 64'(zfun(int'(p.l), int'(p.s))));
            chk("bp_z_prev", 64'(bp_z_prev), 64'(zpfun(int'(p.l), int'(p.s))));
            chk("all_valid", 64'({bp_layer_valid, bp_sample_valid, bp_z_valid, bp_z_prev_valid}), 64'hf);
        end
    endtask

    task automatic do_start(input int n);
        @(negedge clk);
        start      = 1'b1;
        num_epochs = EW'(n);
        @(negedge clk);
        start      = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valids", 64'({bp_layer_valid, bp_sample_valid, bp_z_valid, bp_z_prev_valid}), 64'd0);
        chk("rst_flags", 64'({done, halted, err_flag, act_rd_en, bp_weights_ready}), 64'd0);
        rst  = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("idle_stop_ignored", 64'(busy), 64'd0);

        // Full sequence: 2 epochs x 2 samples x 2 layers
        for (int e = 0; e < 2; e++)
            for (int s = 0; s < SNUM; s++)
                for (int l = LMAX; l >= 0; l--) push(e, s, l);
        rd_pulses = 0; done_cnt = 0;
        do_start(2);
        repeat (8) check_pass();
        wait_for(1, "full_done");
        chk("full_halted", 64'(halted), 64'd0);
        @(negedge clk);
        chk("full_done_pulse", 64'({done, busy}), 64'd0);
        chk("full_done_cnt", 64'(done_cnt), 64'd1);
        chk("full_reads", 64'(rd_pulses), 64'd8);
        chk("rd_strobe_len", 64'(long_rd), 64'd0);
        chk("final_idx", 64'({cur_epoch, cur_sample, cur_layer}), {45'd0, 16'd1, 2'd1, 1'd0});

        // Staggered z ready, then stop during WAIT_W of pass 2
        bp_z_ready = 1'b0;
        push(0, 0, 1);
        push(0, 0, 0);
        rd_pulses = 0;
        do_start(1);
        check_pass();
        @(negedge clk);
        chk("stag_c2_valids", 64'({bp_layer_valid, bp_sample_valid, bp_z_valid, bp_z_prev_valid}), 64'b0010);
        chk("stag_c2_z", 64'(bp_z), 64'(zfun(1, 0)));
        chk("stag_c2_wready", 64'(bp_weights_ready), 64'd0);
        @(negedge clk);
        chk("stag_c3_z_valid", 64'(bp_z_valid), 64'd1);
        chk("stag_c3_z", 64'(bp_z), 64'(zfun(1, 0)));
        chk("stag_c3_wready", 64'(bp_weights_ready), 64'd0);
        bp_z_ready       = 1'b1;
        bp_weights_valid = 1'b0;
        @(negedge clk);
        chk("stag_z_drop", 64'({bp_z_valid, bp_weights_ready}), 64'b01);
        @(negedge clk);
        chk("wready_hold", 64'(bp_weights_ready), 64'd1);
        bp_weights_valid = 1'b1;
        check_pass();
        wait_for(2, "p2_wait_w");
        bp_weights_valid = 1'b0;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("p2_wready_hold", 64'(bp_weights_ready), 64'd1);
        bp_weights_valid = 1'b1;
        wait_for(1, "stop_done");
        chk("stop_halted", 64'(halted), 64'd1);
        @(negedge clk);
        chk("stop_reads", 64'(rd_pulses), 64'd2);

        // Error during ISSUE, num_epochs 0 treated as 1
        push(0, 0, 1);
        rd_pulses = 0;
        do_start(0);
        check_pass();
        bp_error = 1'b1;
        @(negedge clk);
        bp_error = 1'b0;
        chk("err_set", 64'(err_flag), 64'd1);
        wait_for(1, "err_done");
        chk("err_halt", 64'({halted, err_flag}), 64'b11);
        @(negedge clk);
        chk("err_reads", 64'(rd_pulses), 64'd1);
        chk("err_sticky", 64'(err_flag), 64'd1);

        // Restart clears flags, then reset mid-ISSUE
        push(0, 0, 1);
        bp_z_ready = 1'b0;
        do_start(3);
        chk("restart_flags", 64'({err_flag, halted, busy}), 64'b001);
        check_pass();
        #2 rst = 1'b0;
        #1;
        chk("arst_valids", 64'({bp_layer_valid, bp_sample_valid, bp_z_valid, bp_z_prev_valid}), 64'd0);
        chk("arst_ctrl", 64'({busy, done, halted, err_flag, act_rd_en, bp_weights_ready}), 64'd0);
        chk("arst_data", 64'(bp_z), 64'd0);
        chk("arst_idx", 64'({cur_epoch, cur_sample, cur_layer}), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        bp_z_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", 64'({busy, bp_z_valid, act_rd_en}), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
